alu32_arbiter: RTL and testbench

Shares one alu32 instance between two requesters (req0, req1) using a valid/ready handshake on requests and on a single tagged response channel. The block arbitrates between the requesters, registers the granted operands and control code, drives the internal alu32, and captures its result and flags. It then holds the response until the consumer accepts it. It sits between the datapath front ends and the ALU and is the only driver of the ALU's inputs.

---
 rtl/alu32_arbiter_if.sv | 46 ++++
 rtl/alu32_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_alu32_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu32_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : alu32_arbiter_if
// Brief    : Two-requester ALU request channels plus one tagged response channel.
// Revision : 1.0
// ============================================================================
interface alu32_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_A;
    logic [31:0] req0_B;
    logic [2:0]  req0_control;

    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_A;
    logic [31:0] req1_B;
    logic [2:0]  req1_control;

    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_out;
    logic        rsp_overflow;
    logic        rsp_zero;
    logic        rsp_negative;

    modport master (
        output req0_valid, req0_A, req0_B, req0_control,
        input  req0_ready,
        output req1_valid, req1_A, req1_B, req1_control,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_out, rsp_overflow, rsp_zero, rsp_negative,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_A, req0_B, req0_control,
        output req0_ready,
        input  req1_valid, req1_A, req1_B, req1_control,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_out, rsp_overflow, rsp_zero, rsp_negative,
        input  rsp_ready
    );
endinterface
`default_nettype wire

// File: rtl/alu32_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu32_arbiter (with embedded alu32)
// Brief    : Arbitrates two requesters onto one 32-bit ALU, returns tagged results.
// Revision : 1.0
// ============================================================================
`ifndef ALU_AND
`define ALU_AND 3'b000
`define ALU_OR  3'b001
`define ALU_ADD 3'b010
`define ALU_XOR 3'b011
`define ALU_NOR 3'b100
`define ALU_SUB 3'b110
`endif

module alu32 (
    input  wire logic [31:0] i_a,
    input  wire logic [31:0] i_b,
    input  wire logic [2:0]  i_control,
    output logic      [31:0] o_out,
    output logic             o_overflow,
    output logic             o_zero,
    output logic             o_negative
);
    logic [31:0] w_sum;
    logic [31:0] w_diff;

    assign w_sum  = i_a + i_b;
    assign w_diff = i_a - i_b;

    always_comb begin
        o_out      = 32'd0;
        o_overflow = 1'b0;
        case (i_control)
            `ALU_ADD: begin
                o_out      = w_sum;
                o_overflow = (i_a[31] == i_b[31]) && (w_sum[31] != i_a[31]);
            end
            `ALU_SUB: begin
                o_out      = w_diff;
                o_overflow = (i_a[31] != i_b[31]) && (w_diff[31] != i_a[31]);
            end
            `ALU_AND: o_out = i_a & i_b;
            `ALU_OR:  o_out = i_a | i_b;
            `ALU_NOR: o_out = ~(i_a | i_b);
            `ALU_XOR: o_out = i_a ^ i_b;
            default:  o_out = 32'd0;
        endcase
    end

    assign o_zero     = (o_out == 32'd0);
    assign o_negative = o_out[31];
endmodule

module alu32_arbiter #(
    parameter bit RR_EN = 1'b1,
    parameter int CNT_W = 16
) (
    input  wire logic        clk,
    input  wire logic        reset,
    alu32_arbiter_if.slave   bus,
    output logic             busy,
    output logic [CNT_W-1:0] done0_count,
    output logic [CNT_W-1:0] done1_count
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    state_t           r_state;
    logic             r_last_grant;
    logic             r_op_id;
    logic [31:0]      r_op_a;
    logic [31:0]      r_op_b;
    logic [2:0]       r_op_control;
    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [31:0]      r_rsp_out;
    logic             r_rsp_overflow;
    logic             r_rsp_zero;
    logic             r_rsp_negative;
    logic [CNT_W-1:0] r_done0_count;
    logic [CNT_W-1:0] r_done1_count;

    logic             w_grant_valid;
    logic             w_grant_id;
    logic [31:0]      w_alu_out;
    logic             w_alu_overflow;
    logic             w_alu_zero;
    logic             w_alu_negative;

    // Grant is only offered in IDLE; under contention round-robin favours
    // the requester that did not win last time.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_id    = 1'b0;
        if (r_state == S_IDLE) begin
            if (bus.req0_valid && bus.req1_valid) begin
                w_grant_valid = 1'b1;
                w_grant_id    = RR_EN ? ~r_last_grant : 1'b0;
            end else if (bus.req0_valid) begin
                w_grant_valid = 1'b1;
                w_grant_id    = 1'b0;
            end else if (bus.req1_valid) begin
                w_grant_valid = 1'b1;
                w_grant_id    = 1'b1;
            end
        end
    end

    assign bus.req0_ready = w_grant_valid & ~w_grant_id;
    assign bus.req1_ready = w_grant_valid &  w_grant_id;

    alu32 u_alu32 (
        .i_a        (r_op_a),
        .i_b        (r_op_b),
        .i_control  (r_op_control),
        .o_out      (w_alu_out),
        .o_overflow (w_alu_overflow),
        .o_zero     (w_alu_zero),
        .o_negative (w_alu_negative)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_last_grant   <= 1'b1;
            r_op_id        <= 1'b0;
            r_op_a         <= 32'd0;
            r_op_b         <= 32'd0;
            r_op_control   <= 3'd0;
            r_rsp_valid    <= 1'b0;
            r_rsp_id       <= 1'b0;
            r_rsp_out      <= 32'd0;
            r_rsp_overflow <= 1'b0;
            r_rsp_zero     <= 1'b0;
            r_rsp_negative <= 1'b0;
            r_done0_count  <= '0;
            r_done1_count  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_valid) begin
                        r_op_a       <= w_grant_id ? bus.req1_A       : bus.req0_A;
                        r_op_b       <= w_grant_id ? bus.req1_B       : bus.req0_B;
                        r_op_control <= w_grant_id ? bus.req1_control : bus.req0_control;
                        r_op_id      <= w_grant_id;
                        r_last_grant <= w_grant_id;
                        r_state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_rsp_out      <= w_alu_out;
                    r_rsp_overflow <= w_alu_overflow;
                    r_rsp_zero     <= w_alu_zero;
                    r_rsp_negative <= w_alu_negative;
                    r_rsp_id       <= r_op_id;
                    r_rsp_valid    <= 1'b1;
                    r_state        <= S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        if (!r_rsp_id && (r_done0_count != c_CNT_MAX))
                            r_done0_count <= r_done0_count + 1'b1;
                        if (r_rsp_id && (r_done1_count != c_CNT_MAX))
                            r_done1_count <= r_done1_count + 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_id       = r_rsp_id;
    assign bus.rsp_out      = r_rsp_out;
    assign bus.rsp_overflow = r_rsp_overflow;
    assign bus.rsp_zero     = r_rsp_zero;
    assign bus.rsp_negative = r_rsp_negative;

    assign busy        = (r_state != S_IDLE);
    assign done0_count = r_done0_count;
    assign done1_count = r_done1_count;
endmodule
`default_nettype wire

// File: tb/tb_alu32_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu32_arbiter
// Brief    : Directed scoreboard bench; u_rr is round-robin, u_fp is fixed-priority with 2-bit counters.
// Revision : 1.0
// ============================================================================
`ifndef ALU_AND
`define ALU_AND 3'b000
`define ALU_OR  3'b001
`define ALU_ADD 3'b010
`define ALU_XOR 3'b011
`define ALU_NOR 3'b100
`define ALU_SUB 3'b110
`endif

module tb_alu32_arbiter;
    typedef struct packed {
        logic        id;
        logic [31:0] out;
        logic        ovf;
        logic        zero;
        logic        neg;
    } rsp_t;

    logic        clk = 1'b0;
    logic        reset_rr;
    logic        reset_fp;
    logic        busy_rr, busy_fp;
    logic [15:0] d0_rr, d1_rr;
    logic [1:0]  d0_fp, d1_fp;

    int   checks = 0;
    int   errors = 0;
    rsp_t q_rr[$];
    rsp_t q_fp[$];
    rsp_t mon_obs, mon_exp, hold_exp;

    alu32_arbiter_if bus_rr ();
    alu32_arbiter_if bus_fp ();

    alu32_arbiter #(.RR_EN(1'b1), .CNT_W(16)) u_rr (
        .clk(clk), .reset(reset_rr), .bus(bus_rr), .busy(busy_rr),
        .done0_count(d0_rr), .done1_count(d1_rr)
    );

    alu32_arbiter #(.RR_EN(1'b0), .CNT_W(2)) u_fp (
        .clk(clk), .reset(reset_fp), .bus(bus_fp), .busy(busy_fp),
        .done0_count(d0_fp), .done1_count(d1_fp)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required to finish");
        $fatal(1, "timeout");
    end

    function automatic rsp_t model(input logic id, input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] c);
        rsp_t r;
        logic signed [32:0] s;
        r.id  = id;
        r.ovf = 1'b0;
        r.out = 32'd0;
        case (c)
            `ALU_ADD: begin
                s = $signed({a[31], a}) + $signed({b[31], b});
                r.out = s[31:0];
                r.ovf = s[32] ^ s[31];
            end
            `ALU_SUB: begin
                s = $signed({a[31], a}) - $signed({b[31], b});
                r.out = s[31:0];
                r.ovf = s[32] ^ s[31];
            end
            `ALU_AND: r.out = a & b;
            `ALU_OR:  r.out = a | b;
            `ALU_NOR: r.out = ~(a | b);
            `ALU_XOR: r.out = a ^ b;
            default:  r.out = 32'd0;
        endcase
        r.zero = (r.out == 32'd0);
        r.neg  = r.out[31];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every accepted response is compared with the oldest expectation.
    always @(negedge clk) begin
        if (bus_rr.rsp_valid && bus_rr.rsp_ready) begin
            mon_obs = {bus_rr.rsp_id, bus_rr.rsp_out, bus_rr.rsp_overflow,
                       bus_rr.rsp_zero, bus_rr.rsp_negative};
            if (q_rr.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL rr_unexpected_rsp: observed response %0h expected none", mon_obs);
            end else begin
                mon_exp = q_rr.pop_front();
                chk("rr_rsp", 64'(mon_obs), 64'(mon_exp));
            end
        end
        if (bus_fp.rsp_valid && bus_fp.rsp_ready) begin
            mon_obs = {bus_fp.rsp_id, bus_fp.rsp_out, bus_fp.rsp_overflow,
                       bus_fp.rsp_zero, bus_fp.rsp_negative};
            if (q_fp.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL fp_unexpected_rsp: observed response %0h expected none", mon_obs);
            end else begin
                mon_exp = q_fp.pop_front();
                chk("fp_rsp", 64'(mon_obs), 64'(mon_exp));
            end
        end
    end

    task automatic drive(input bit fp, input bit id, input bit v, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] c);
        if (!fp && !id) begin
            bus_rr.req0_valid = v; bus_rr.req0_A = a; bus_rr.req0_B = b; bus_rr.req0_control = c;
        end else if (!fp) begin
            bus_rr.req1_valid = v; bus_rr.req1_A = a; bus_rr.req1_B = b; bus_rr.req1_control = c;
        end else if (!id) begin
            bus_fp.req0_valid = v; bus_fp.req0_A = a; bus_fp.req0_B = b; bus_fp.req0_control = c;
        end else begin
            bus_fp.req1_valid = v; bus_fp.req1_A = a; bus_fp.req1_B = b; bus_fp.req1_control = c;
        end
    endtask

    function automatic bit ready_of(input bit fp, input bit id);
        if (!fp) return id ? bus_rr.req1_ready : bus_rr.req0_ready;
        return id ? bus_fp.req1_ready : bus_fp.req0_ready;
    endfunction

    // Returns one time unit after the handshake edge (DUT then in EXEC).
    task automatic send(input bit fp, input bit id, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] c, input bit push);
        bit got = 1'b0;
        int n = 0;
        if (push) begin
            if (fp) q_fp.push_back(model(id, a, b, c));
            else    q_rr.push_back(model(id, a, b, c));
        end
        drive(fp, id, 1'b1, a, b, c);
        while (!got && n < 40) begin
            @(negedge clk);
            got = ready_of(fp, id);
            n++;
        end
        if (!got) begin
            checks++;
            errors++;
            $error("FAIL send_timeout: observed no ready for id %0d, expected a handshake", id);
        end
        @(posedge clk); #1;
        drive(fp, id, 1'b0, a, b, c);
    endtask

    task automatic wait_idle(input bit fp);
        int n = 0;
        while ((fp ? q_fp.size() : q_rr.size()) != 0 && n < 60) begin
            @(negedge clk); #1;
            n++;
        end
        if ((fp ? q_fp.size() : q_rr.size()) != 0) begin
            checks++;
            errors++;
            $error("FAIL rsp_timeout: observed %0d pending responses, expected 0",
                   fp ? q_fp.size() : q_rr.size());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int k;
        int n;
        bus_rr.req0_valid = 0; bus_rr.req0_A = 0; bus_rr.req0_B = 0; bus_rr.req0_control = 0;
        bus_rr.req1_valid = 0; bus_rr.req1_A = 0; bus_rr.req1_B = 0; bus_rr.req1_control = 0;
        bus_fp.req0_valid = 0; bus_fp.req0_A = 0; bus_fp.req0_B = 0; bus_fp.req0_control = 0;
        bus_fp.req1_valid = 0; bus_fp.req1_A = 0; bus_fp.req1_B = 0; bus_fp.req1_control = 0;
        bus_rr.rsp_ready = 1'b1;
        bus_fp.rsp_ready = 1'b1;
        reset_rr = 1'b1;
        reset_fp = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_rr = 1'b0;
        reset_fp = 1'b0;

        // Reset state
        @(negedge clk);
        chk("reset_rsp_valid", bus_rr.rsp_valid, 0);
        chk("reset_rsp_fields", {bus_rr.rsp_id, bus_rr.rsp_out, bus_rr.rsp_overflow,
                                 bus_rr.rsp_zero, bus_rr.rsp_negative}, 0);
        chk("reset_busy", busy_rr, 0);
        chk("reset_counts", {d0_rr, d1_rr}, 0);
        chk("reset_fp_counts", {d0_fp, d1_fp, busy_fp}, 0);
        @(posedge clk); #1;

        // Single add with 2-cycle latency
        send(1'b0, 1'b0, 32'd8, 32'd4, `ALU_ADD, 1'b1);
        @(negedge clk);
        chk("lat_exec_no_rsp", {bus_rr.rsp_valid, busy_rr}, 2'b01);
        @(negedge clk);
        chk("lat_rsp_valid", bus_rr.rsp_valid, 1);
        @(posedge clk); #1;
        wait_idle(1'b0);
        chk("add_done0", d0_rr, 1);

        // Overflow then zero from requester 1
        send(1'b0, 1'b1, 32'h7fffffff, 32'd1, `ALU_ADD, 1'b1);
        wait_idle(1'b0);
        send(1'b0, 1'b1, 32'd5, 32'd5, `ALU_SUB, 1'b1);
        wait_idle(1'b0);
        chk("req1_done1", d1_rr, 2);

        // Round-robin contention: last winner was 1, so order is 0,1,0,1
        for (int i = 0; i < 2; i++) begin
            q_rr.push_back(model(1'b0, 32'hff, 32'h83, `ALU_XOR));
            q_rr.push_back(model(1'b1, 32'ha3, 32'h11, `ALU_XOR));
        end
        drive(1'b0, 1'b0, 1'b1, 32'hff, 32'h83, `ALU_XOR);
        drive(1'b0, 1'b1, 1'b1, 32'ha3, 32'h11, `ALU_XOR);
        k = 0;
        n = 0;
        while (k < 4 && n < 40) begin
            @(negedge clk);
            n++;
            if (bus_rr.req0_ready || bus_rr.req1_ready) begin
                chk("rr_grant", {bus_rr.req0_ready, bus_rr.req1_ready}, (k % 2) ? 2'b01 : 2'b10);
                k++;
            end
        end
        if (k < 4) begin
            checks++;
            errors++;
            $error("FAIL rr_grant_timeout: observed %0d grants, expected 4", k);
        end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'hff, 32'h83, `ALU_XOR);
        drive(1'b0, 1'b1, 1'b0, 32'ha3, 32'h11, `ALU_XOR);
        wait_idle(1'b0);
        chk("rr_counts", {d0_rr, d1_rr}, {16'd3, 16'd4});

        // Back-pressure hold during RESP
        bus_rr.rsp_ready = 1'b0;
        hold_exp = model(1'b0, 32'd0, 32'd0, `ALU_NOR);
        send(1'b0, 1'b0, 32'd0, 32'd0, `ALU_NOR, 1'b1);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            bus_rr.req0_valid = 1'b1;
            bus_rr.req1_valid = 1'b1;
            @(negedge clk);
            chk("hold_rsp", 64'({bus_rr.rsp_valid, bus_rr.rsp_id, bus_rr.rsp_out, bus_rr.rsp_overflow,
                                 bus_rr.rsp_zero, bus_rr.rsp_negative}), 64'({1'b1, hold_exp}));
            chk("hold_ready", {bus_rr.req0_ready, bus_rr.req1_ready}, 2'b00);
            chk("hold_counts", {d0_rr, d1_rr}, {16'd3, 16'd4});
        end
        @(posedge clk); #1;
        bus_rr.req0_valid = 1'b0;
        bus_rr.req1_valid = 1'b0;
        bus_rr.rsp_ready  = 1'b1;
        wait_idle(1'b0);
        chk("hold_release", {d0_rr, d1_rr, busy_rr}, {16'd4, 16'd4, 1'b0});

        // Reset while EXEC drops the operation
        send(1'b0, 1'b1, 32'd5, 32'd5, `ALU_SUB, 1'b0);
        reset_rr = 1'b1;
        @(posedge clk); #1;
        reset_rr = 1'b0;
        @(negedge clk);
        chk("exec_reset_state", {bus_rr.rsp_valid, busy_rr}, 2'b00);
        chk("exec_reset_counts", {d0_rr, d1_rr}, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("exec_reset_no_rsp", bus_rr.rsp_valid, 0);
        end
        @(posedge clk); #1;
        send(1'b0, 1'b0, 32'd8, 32'd4, `ALU_ADD, 1'b1);
        wait_idle(1'b0);
        chk("after_reset_done0", d0_rr, 1);

        // Saturating 2-bit counter
        for (int i = 0; i < 5; i++) begin
            send(1'b1, 1'b0, 32'd1, 32'd1, `ALU_AND, 1'b1);
            wait_idle(1'b1);
            chk("fp_done0_sat", d0_fp, (i + 1 > 3) ? 3 : i + 1);
        end

        // Fixed priority: req0 always wins while valid
        drive(1'b1, 1'b0, 1'b1, 32'hff, 32'h83, `ALU_XOR);
        drive(1'b1, 1'b1, 1'b1, 32'ha3, 32'h11, `ALU_XOR);
        for (int i = 0; i < 3; i++) q_fp.push_back(model(1'b0, 32'hff, 32'h83, `ALU_XOR));
        k = 0;
        n = 0;
        while (k < 3 && n < 40) begin
            @(negedge clk);
            n++;
            if (bus_fp.req0_ready || bus_fp.req1_ready) begin
                chk("fp_grant", {bus_fp.req0_ready, bus_fp.req1_ready}, 2'b10);
                k++;
            end
        end
        if (k < 3) begin
            checks++;
            errors++;
            $error("FAIL fp_grant_timeout: observed %0d grants, expected 3", k);
        end
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 32'hff, 32'h83, `ALU_XOR);
        send(1'b1, 1'b1, 32'ha3, 32'h11, `ALU_XOR, 1'b1);
        wait_idle(1'b1);
        chk("fp_counts", {d0_fp, d1_fp}, {2'd3, 2'd1});

        chk("rr_queue_empty", q_rr.size(), 0);
        chk("fp_queue_empty", q_fp.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
